// File: rtl/pwm_fet_driver_array.sv
// N-channel complementary half-bridge PWM driver with a Wishbone slave port.
// Each channel has programmable period, duty and dead-time. Period and duty
// are shadowed so a new value only takes effect at a period boundary, and a
// latched fault forces every gate drive off.
//
// Wishbone handshake: a request is stb & cyc while ack is low. It is accepted
// on that clock edge; ack is high for exactly the following cycle with read
// data valid in it, then drops. A strobe still held re-acks after a one-cycle
// gap. Read data is 0 outside the ack cycle, and reads as 0 for writes.
module pwm_fet_driver_array #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 16,
  parameter int          DT_W      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              fault_i,
  output logic [NUM_CH-1:0] hs_o,
  output logic [NUM_CH-1:0] ls_o,
  output logic              irq_o
);

  // Global control and fault state
  logic gen;
  logic fault_ie;
  logic fault_q;
  logic fault_s1;
  logic fault_s2;

  // Per-channel software-visible registers
  logic [CNT_W-1:0] period_r [NUM_CH];
  logic [CNT_W-1:0] duty_r   [NUM_CH];
  logic [DT_W-1:0]  dt_r     [NUM_CH];
  logic [NUM_CH-1:0] en_r;
  logic [NUM_CH-1:0] inv_r;

  // Bus decode
  logic        req;
  logic        hit;
  logic        wr_en;
  logic [5:0]  word_off;
  logic [3:0]  ch_field;
  logic [1:0]  reg_sel;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic        gstat_clr;

  // Byte-lane masks truncated to each register width
  logic [CNT_W-1:0] cnt_mask;
  logic [CNT_W-1:0] cnt_wdat;
  logic [DT_W-1:0]  dt_mask;
  logic [DT_W-1:0]  dt_wdat;

  // The byte offset within a word carries no information for 32-bit registers
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr_en    = req & wbs_we_i & hit;
  assign word_off = wbs_adr_i[7:2];
  assign ch_field = wbs_adr_i[7:4];
  assign reg_sel  = wbs_adr_i[3:2];

  assign cnt_mask = wmask[CNT_W-1:0];
  assign cnt_wdat = wbs_dat_i[CNT_W-1:0];
  assign dt_mask  = wmask[DT_W-1:0];
  assign dt_wdat  = wbs_dat_i[DT_W-1:0];

  assign gstat_clr = wr_en & (word_off == 6'h01) & wbs_sel_i[0] & wbs_dat_i[0];

  assign irq_o = fault_q & fault_ie;

  // Expand byte enables to a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) begin
      wmask[8*i +: 8] = {8{wbs_sel_i[i]}};
    end
  end

  // Read multiplexer; anything not mapped reads as zero
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (word_off == 6'h00) begin
        rdata = {30'd0, fault_ie, gen};
      end else if (word_off == 6'h01) begin
        rdata = {31'd0, fault_q};
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_field == 4'(c + 1)) begin
          case (reg_sel)
            2'd0:    rdata = 32'(period_r[c]);
            2'd1:    rdata = 32'(duty_r[c]);
            2'd2:    rdata = 32'(dt_r[c]);
            default: rdata = {30'd0, inv_r[c], en_r[c]};
          endcase
        end
      end
    end
  end

  // Wishbone ack and registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else if (req) begin
      wbs_ack_o <= 1'b1;
      wbs_dat_o <= wbs_we_i ? 32'd0 : rdata;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end
  end

  // Global control register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gen      <= 1'b0;
      fault_ie <= 1'b0;
    end else if (wr_en && (word_off == 6'h00)) begin
      if (wbs_sel_i[0]) begin
        gen      <= wbs_dat_i[0];
        fault_ie <= wbs_dat_i[1];
      end
    end
  end

  // Fault synchroniser and latch; a live fault beats a software clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      fault_s1 <= 1'b0;
      fault_s2 <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      fault_s1 <= fault_i;
      fault_s2 <= fault_s1;
      if (fault_s2) begin
        fault_q <= 1'b1;
      end else if (gstat_clr) begin
        fault_q <= 1'b0;
      end
    end
  end

  // Per-channel configuration registers with byte-lane writes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        period_r[c] <= '0;
        duty_r[c]   <= '0;
        dt_r[c]     <= '0;
      end
      en_r  <= '0;
      inv_r <= '0;
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_field == 4'(c + 1)) begin
          case (reg_sel)
            2'd0: period_r[c] <= (period_r[c] & ~cnt_mask) | (cnt_wdat & cnt_mask);
            2'd1: duty_r[c]   <= (duty_r[c] & ~cnt_mask) | (cnt_wdat & cnt_mask);
            2'd2: dt_r[c]     <= (dt_r[c] & ~dt_mask) | (dt_wdat & dt_mask);
            default: begin
              if (wbs_sel_i[0]) begin
                en_r[c]  <= wbs_dat_i[0];
                inv_r[c] <= wbs_dat_i[1];
              end
            end
          endcase
        end
      end
    end
  end

  // Channel engines: counter, shadow registers, dead-time and gate drives
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_sh;
    logic [CNT_W-1:0] duty_sh;
    logic [DT_W-1:0]  dt_cnt;
    logic             pwm_prev;
    logic             hs_q;
    logic             ls_q;

    logic             running;
    logic             pwm;
    logic             wrap;
    logic             pwm_edge;
    logic [DT_W-1:0]  elapsed;
    logic             dt_done;
    logic             hs_nx;
    logic             ls_raw;
    logic             ls_nx;

    assign running  = gen & en_r[c] & ~fault_q;
    assign pwm      = running & (cnt < duty_sh);
    assign wrap     = (cnt == period_sh);
    assign pwm_edge = pwm ^ pwm_prev;
    // Cycles pwm has held its present level, zero on the cycle it changes
    assign elapsed  = pwm_edge ? '0 : dt_cnt;
    assign dt_done  = (elapsed >= dt_r[c]);
    assign hs_nx    = pwm & dt_done;
    assign ls_raw   = running & ~pwm & dt_done;
    // Inverted low side is still masked by the high side so they never overlap
    assign ls_nx    = running & ((ls_raw ^ inv_r[c]) & ~hs_nx);

    assign hs_o[c] = hs_q;
    assign ls_o[c] = ls_q;

    // Counter, shadow reload at wrap or while idle, registered gate drives
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        cnt       <= '0;
        period_sh <= '0;
        duty_sh   <= '0;
        dt_cnt    <= '0;
        pwm_prev  <= 1'b0;
        hs_q      <= 1'b0;
        ls_q      <= 1'b0;
      end else if (!running) begin
        cnt       <= '0;
        period_sh <= period_r[c];
        duty_sh   <= duty_r[c];
        dt_cnt    <= '0;
        pwm_prev  <= 1'b0;
        hs_q      <= 1'b0;
        ls_q      <= 1'b0;
      end else begin
        if (wrap) begin
          cnt       <= '0;
          period_sh <= period_r[c];
          duty_sh   <= duty_r[c];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        pwm_prev <= pwm;
        if (pwm_edge) begin
          dt_cnt <= DT_W'(1);
        end else if (dt_cnt != '1) begin
          dt_cnt <= dt_cnt + DT_W'(1);
        end
        hs_q <= hs_nx;
        ls_q <= ls_nx;
      end
    end
  end

endmodule

// File: tb/tb_pwm_fet_driver_array.sv
// Bench for pwm_fet_driver_array: a cycle model derived from the register map
// and the PWM/dead-time rules runs beside the DUT and every output is compared
// against it each cycle; directed scenarios also check hand-computed numbers.
module tb_pwm_fet_driver_array;
  localparam int NCH = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]     sel = 4'h0;
  logic [31:0]    wdat = '0, adr = '0;
  logic           ack;
  logic [31:0]    dat_o;
  logic           fault_i = 1'b0;
  logic [NCH-1:0] hs_o, ls_o;
  logic           irq_o;

  pwm_fet_driver_array #(.NUM_CH(NCH), .CNT_W(16), .DT_W(8), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .fault_i  (fault_i),
    .hs_o     (hs_o),
    .ls_o     (ls_o),
    .irq_o    (irq_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_gen, m_fie, m_fault, m_s1, m_s2;
  int m_per[NCH], m_duty[NCH], m_dt[NCH], m_en[NCH], m_inv[NCH];
  int m_pos[NCH], m_psh[NCH], m_dsh[NCH], m_run[NCH], m_last[NCH];
  logic           m_ack;
  logic [31:0]    m_dat;
  logic [NCH-1:0] m_hs, m_ls;

  function automatic int bmerge(input int old, input logic [31:0] d, input logic [3:0] s, input int w);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    r = r & ((32'd1 << w) - 32'd1);
    return int'(r);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int o, ch;
    if (a[31:8] != BASE[31:8]) return 32'd0;
    o = int'(a[7:0]) / 4;
    ch = o / 4;
    if (o == 0) return 32'(m_fie * 2 + m_gen);
    if (o == 1) return 32'(m_fault);
    if (ch >= 1 && ch <= NCH) begin
      case (o % 4)
        0: return 32'(m_per[ch-1]);
        1: return 32'(m_duty[ch-1]);
        2: return 32'(m_dt[ch-1]);
        default: return 32'(m_inv[ch-1] * 2 + m_en[ch-1]);
      endcase
    end
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    logic req, clr, running, pwm, done, lsraw;
    logic [NCH-1:0] nhs, nls;
    int o, ch, v;
    if (rst) begin
      m_gen = 0; m_fie = 0; m_fault = 0; m_s1 = 0; m_s2 = 0;
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = 0; m_duty[c] = 0; m_dt[c] = 0; m_en[c] = 0; m_inv[c] = 0;
        m_pos[c] = 0; m_psh[c] = 0; m_dsh[c] = 0; m_run[c] = 0; m_last[c] = 0;
      end
      m_ack = 0; m_dat = 0; m_hs = 0; m_ls = 0;
    end else begin
      nhs = 0; nls = 0;
      for (int c = 0; c < NCH; c++) begin
        running = (m_gen != 0) && (m_en[c] != 0) && (m_fault == 0);
        pwm = running && (m_pos[c] < m_dsh[c]);
        if (!running) begin
          m_run[c] = 0; m_last[c] = 0;
        end else begin
          m_run[c] = (int'(pwm) == m_last[c]) ? m_run[c] + 1 : 1;
          m_last[c] = int'(pwm);
        end
        done = running && (m_run[c] - 1 >= m_dt[c]);
        nhs[c] = pwm && done;
        lsraw = running && !pwm && done;
        nls[c] = running && ((lsraw ^ (m_inv[c] != 0)) && !nhs[c]);
        if (!running || m_pos[c] == m_psh[c]) begin
          m_pos[c] = 0; m_psh[c] = m_per[c]; m_dsh[c] = m_duty[c];
        end else begin
          m_pos[c]++;
        end
      end
      req = stb && cyc && !m_ack;
      clr = 0;
      if (req) begin
        m_dat = we ? 32'd0 : m_read(adr);
        m_ack = 1;
        if (we && adr[31:8] == BASE[31:8]) begin
          o = int'(adr[7:0]) / 4;
          ch = o / 4;
          if (o == 0) begin
            v = bmerge(m_fie * 2 + m_gen, wdat, sel, 2);
            m_gen = v % 2; m_fie = v / 2;
          end else if (o == 1) begin
            clr = sel[0] && wdat[0];
          end else if (ch >= 1 && ch <= NCH) begin
            case (o % 4)
              0: m_per[ch-1]  = bmerge(m_per[ch-1], wdat, sel, 16);
              1: m_duty[ch-1] = bmerge(m_duty[ch-1], wdat, sel, 16);
              2: m_dt[ch-1]   = bmerge(m_dt[ch-1], wdat, sel, 8);
              default: begin
                v = bmerge(m_inv[ch-1] * 2 + m_en[ch-1], wdat, sel, 2);
                m_en[ch-1] = v % 2; m_inv[ch-1] = v / 2;
              end
            endcase
          end
        end
      end else begin
        m_ack = 0; m_dat = 0;
      end
      if (m_s2 != 0) m_fault = 1;
      else if (clr) m_fault = 0;
      m_s2 = m_s1;
      m_s1 = int'(fault_i);
      m_hs = nhs; m_ls = nls;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("hs_o", 32'(hs_o), 32'(m_hs));
      check("ls_o", 32'(ls_o), 32'(m_ls));
      check("ack", 32'(ack), 32'(m_ack));
      check("dat_o", dat_o, m_dat);
      check("irq_o", 32'(irq_o), 32'((m_fault != 0) && (m_fie != 0)));
      check("no_overlap", 32'(hs_o & ls_o), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic w, output logic [31:0] rd);
    int lat;
    @(negedge clk);
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ack || lat >= 10) break;
    end
    rd = dat_o;
    stb = 0; cyc = 0; we = 0;
    check("ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(a, d, 4'hF, 1'b1, rd);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 32'd0, 4'hF, 1'b0, rd);
    check(name, rd, exp);
  endtask

  function automatic logic [31:0] ch_addr(input int c, input int r);
    return BASE + 32'(16 * (c + 1) + 4 * r);
  endfunction

  function automatic logic get_sig(input int c, input bit use_ls);
    return use_ls ? ls_o[c] : hs_o[c];
  endfunction

  // Length of the next full run of the given level on hs_o/ls_o of a channel
  task automatic measure_run(input int c, input bit use_ls, input bit lvl, output int len);
    int t;
    t = 0;
    while (get_sig(c, use_ls) == lvl && t < 100) begin @(negedge clk); t++; end
    while (get_sig(c, use_ls) != lvl && t < 200) begin @(negedge clk); t++; end
    len = 0;
    while (get_sig(c, use_ls) == lvl && len < 100) begin @(negedge clk); len++; end
    if (t >= 200) len = -1;
  endtask

  task automatic count_window(input int c, input int n, output int nh, output int nl);
    nh = 0; nl = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nh += int'(hs_o[c]);
      nl += int'(ls_o[c]);
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int nh, nl, l1, l2, d;
    logic [31:0] rd;

    repeat (3) @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    rst = 0;
    check("reset_hs", 32'(hs_o), 32'd0);
    check("reset_ls", 32'(ls_o), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_irq", 32'(irq_o), 32'd0);
    rd_chk("rd_gctrl_reset", BASE, 32'd0);
    rd_chk("rd_per0_reset", ch_addr(0, 0), 32'd0);

    // Channel setup: ch0 plain, ch1 with dead-time, ch2 short pulse
    wr(ch_addr(0, 0), 9);  wr(ch_addr(0, 1), 3);  wr(ch_addr(0, 2), 0); wr(ch_addr(0, 3), 1);
    wr(ch_addr(1, 0), 19); wr(ch_addr(1, 1), 10); wr(ch_addr(1, 2), 2); wr(ch_addr(1, 3), 1);
    wr(ch_addr(2, 0), 9);  wr(ch_addr(2, 1), 1);  wr(ch_addr(2, 2), 3); wr(ch_addr(2, 3), 1);
    wr(BASE, 32'd1);
    repeat (40) @(negedge clk);

    count_window(0, 20, nh, nl);
    check("ch0_hs_count", 32'(nh), 32'd6);
    check("ch0_ls_count", 32'(nl), 32'd14);
    count_window(1, 20, nh, nl);
    check("ch1_hs_count", 32'(nh), 32'd8);
    check("ch1_ls_count", 32'(nl), 32'd8);
    count_window(2, 20, nh, nl);
    check("ch2_hs_count", 32'(nh), 32'd0);
    check("ch2_ls_count", 32'(nl), 32'd12);
    measure_run(1, 1'b0, 1'b1, l1);
    check("ch1_hs_pulse", 32'(l1), 32'd8);
    measure_run(1, 1'b1, 1'b0, l1);
    check("ch1_ls_low", 32'(l1), 32'd12);
    measure_run(2, 1'b1, 1'b0, l1);
    check("ch2_ls_gap", 32'(l1), 32'd4);

    // Duty change mid-pulse shows up only in the following period
    fork
      begin
        measure_run(0, 1'b0, 1'b1, l1);
        measure_run(0, 1'b0, 1'b1, l2);
      end
      begin
        d = 0;
        while (hs_o[0] && d < 50) begin @(negedge clk); d++; end
        while (!hs_o[0] && d < 100) begin @(negedge clk); d++; end
        wr(ch_addr(0, 1), 5);
      end
    join
    check("duty_old_pulse", 32'(l1), 32'd3);
    check("duty_new_pulse", 32'(l2), 32'd5);

    // Byte lanes, width truncation and unmapped space on ch3
    wb_xfer(ch_addr(3, 0), 32'h0000_ABCD, 4'b0001, 1'b1, rd);
    rd_chk("sel_byte0", ch_addr(3, 0), 32'h0000_00CD);
    wb_xfer(ch_addr(3, 0), 32'h0000_1200, 4'b0010, 1'b1, rd);
    rd_chk("sel_byte1", ch_addr(3, 0), 32'h0000_12CD);
    wr(ch_addr(3, 2), 32'hFFFF_FFFF);
    rd_chk("dt_width", ch_addr(3, 2), 32'h0000_00FF);
    wr(BASE + 32'h50, 32'hFFFF_FFFF);
    rd_chk("unmapped_ch", BASE + 32'h50, 32'd0);
    rd_chk("unmapped_08", BASE + 32'h08, 32'd0);
    rd_chk("outside_base", 32'h4000_0010, 32'd0);

    // Inverted low side on ch3
    wr(ch_addr(3, 0), 7); wr(ch_addr(3, 1), 4); wr(ch_addr(3, 2), 1); wr(ch_addr(3, 3), 3);
    rd_chk("ctrl3_rd", ch_addr(3, 3), 32'd3);
    repeat (20) @(negedge clk);
    count_window(3, 16, nh, nl);
    check("ch3_hs_count", 32'(nh), 32'd6);
    check("ch3_inv_ls_count", 32'(nl), 32'd4);

    // Fault pulse with interrupt enabled
    wr(BASE, 32'd3);
    @(negedge clk);
    fault_i = 1;
    @(negedge clk);
    fault_i = 0;
    repeat (3) @(negedge clk);
    check("fault_hs_off", 32'(hs_o), 32'd0);
    check("fault_ls_off", 32'(ls_o), 32'd0);
    check("fault_irq", 32'(irq_o), 32'd1);
    rd_chk("gstat_set", BASE + 32'h4, 32'd1);
    wr(BASE + 32'h4, 32'd1);
    d = 0;
    do begin @(negedge clk); d++; end while (!hs_o[0] && d < 50);
    check("restart_delay", 32'(d), 32'd1);
    l1 = 0;
    while (hs_o[0] && l1 < 50) begin l1++; @(negedge clk); end
    check("restart_pulse", 32'(l1), 32'd5);
    rd_chk("gstat_clear", BASE + 32'h4, 32'd0);

    // Clear while the fault input is still high leaves the latch set
    fault_i = 1;
    repeat (4) @(negedge clk);
    wr(BASE + 32'h4, 32'd1);
    rd_chk("gstat_held", BASE + 32'h4, 32'd1);
    check("held_irq", 32'(irq_o), 32'd1);
    fault_i = 0;
    repeat (3) @(negedge clk);
    wr(BASE + 32'h4, 32'd1);
    rd_chk("gstat_released", BASE + 32'h4, 32'd0);
    repeat (30) @(negedge clk);

    // Reset in the middle of operation
    rst = 1;
    @(negedge clk);
    check("midrst_hs", 32'(hs_o), 32'd0);
    check("midrst_ls", 32'(ls_o), 32'd0);
    check("midrst_irq", 32'(irq_o), 32'd0);
    rst = 0;
    rd_chk("midrst_gctrl", BASE, 32'd0);
    rd_chk("midrst_per1", ch_addr(1, 0), 32'd0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
